// File: rtl/ladybird_config.sv
// rtl/ladybird_config.sv - shared bus width and arbiter state encoding
package ladybird_config;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ladybird_rr_pick.sv
// rtl/ladybird_rr_pick.sv - combinational 2-way round-robin chooser
module ladybird_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant_idx,
  output logic       o_valid
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    o_valid = |i_req;
    if (&i_req) begin
      o_grant_idx = ~i_last;
    end else begin
      o_grant_idx = i_req[1];
    end
  end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// rtl/ladybird_bus_arbiter.sv - D-bus/I-bus arbiter for one shared peripheral port with response watchdog
module ladybird_bus_arbiter
  import ladybird_config::*;
#(
  parameter int XLEN    = ladybird_config::XLEN,
  parameter int TIMEOUT = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [1:0]             i_m_req,
  input  logic [1:0][XLEN-1:0]   i_m_addr,
  input  logic [1:0][XLEN/8-1:0] i_m_wstrb,
  input  logic [1:0][XLEN-1:0]   i_m_wdata,
  output logic [1:0]             o_m_gnt,
  output logic [1:0]             o_m_data_gnt,
  output logic [1:0][XLEN-1:0]   o_m_rdata,
  output logic [1:0]             o_m_err,
  output logic                   o_p_req,
  output logic [XLEN-1:0]        o_p_addr,
  output logic [XLEN/8-1:0]      o_p_wstrb,
  output logic [XLEN-1:0]        o_p_wdata,
  input  logic                   i_p_gnt,
  input  logic                   i_p_data_gnt,
  input  logic [XLEN-1:0]        i_p_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          r_owner;
  logic          w_owner_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [TW-1:0] r_tmo_cnt;
  logic [TW-1:0] w_tmo_cnt_nxt;
  logic          w_pick_idx;
  logic          w_pick_valid;

  ladybird_rr_pick u_pick (
    .i_req       (i_m_req),
    .i_last      (r_last),
    .o_grant_idx (w_pick_idx),
    .o_valid     (w_pick_valid)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_tmo_cnt_nxt = r_tmo_cnt;
    o_m_gnt       = '0;
    o_m_data_gnt  = '0;
    o_m_rdata     = '0;
    o_m_err       = '0;
    o_p_req       = 1'b0;
    o_p_addr      = '0;
    o_p_wstrb     = '0;
    o_p_wdata     = '0;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt = w_pick_idx;
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        o_p_req          = 1'b1;
        o_p_addr         = i_m_addr[r_owner];
        o_p_wstrb        = i_m_wstrb[r_owner];
        o_p_wdata        = i_m_wdata[r_owner];
        o_m_gnt[r_owner] = i_p_gnt;
        if (i_p_gnt) begin
          // A zero-latency peripheral completes the whole transaction here.
          if (i_p_data_gnt) begin
            o_m_data_gnt[r_owner] = 1'b1;
            o_m_rdata[r_owner]    = i_p_rdata;
            w_last_nxt            = r_owner;
            w_state_nxt           = IDLE;
          end else begin
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        if (i_p_data_gnt) begin
          o_m_data_gnt[r_owner] = 1'b1;
          o_m_rdata[r_owner]    = i_p_rdata;
          w_last_nxt            = r_owner;
          w_state_nxt           = IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          o_m_data_gnt[r_owner] = 1'b1;
          o_m_err[r_owner]      = 1'b1;
          w_last_nxt            = r_owner;
          w_state_nxt           = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  a_req_held_in_issue: assert property (
    @(posedge i_clk) disable iff (i_arst) (r_state == ISSUE) |-> i_m_req[r_owner]
  );

  // Stray or late data grants while idle are dropped; this only records that it happened.
  c_stray_data_gnt: cover property (
    @(posedge i_clk) disable iff (i_arst) (r_state == IDLE) && i_p_data_gnt
  );

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb/tb_ladybird_bus_arbiter.sv - randomized scoreboard bench for ladybird_bus_arbiter
module tb_ladybird_bus_arbiter;

  localparam int XLEN = 32;
  localparam int SW   = XLEN / 8;
  localparam int TMO  = 8;

  logic                 clk = 1'b0;
  logic                 arst;
  logic [1:0]           m_req;
  logic [1:0][XLEN-1:0] m_addr;
  logic [1:0][SW-1:0]   m_wstrb;
  logic [1:0][XLEN-1:0] m_wdata;
  logic [1:0]           m_gnt;
  logic [1:0]           m_data_gnt;
  logic [1:0][XLEN-1:0] m_rdata;
  logic [1:0]           m_err;
  logic                 p_req;
  logic [XLEN-1:0]      p_addr;
  logic [SW-1:0]        p_wstrb;
  logic [XLEN-1:0]      p_wdata;
  logic                 p_gnt;
  logic                 p_data_gnt;
  logic [XLEN-1:0]      p_rdata;

  ladybird_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_m_req      (m_req),
    .i_m_addr     (m_addr),
    .i_m_wstrb    (m_wstrb),
    .i_m_wdata    (m_wdata),
    .o_m_gnt      (m_gnt),
    .o_m_data_gnt (m_data_gnt),
    .o_m_rdata    (m_rdata),
    .o_m_err      (m_err),
    .o_p_req      (p_req),
    .o_p_addr     (p_addr),
    .o_p_wstrb    (p_wstrb),
    .o_p_wdata    (p_wdata),
    .i_p_gnt      (p_gnt),
    .i_p_data_gnt (p_data_gnt),
    .i_p_rdata    (p_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic            m;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [SW-1:0]   wstrb;
  } gnt_exp_t;

  typedef struct {
    int              cyc;
    logic            m;
    logic [XLEN-1:0] rdata;
    logic            err;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Requester and peripheral model state (transaction level).
  logic [1:0] busy;
  int         gap[2];
  int         left[2];
  int         phase;
  int         gdly;
  int         ddly;
  int         k;
  logic       own;
  logic       last;
  logic       idle_last;
  logic       resp_last;
  logic [1:0] req_last;
  logic       hold_gnt;
  logic       hold_data;
  logic [1:0] s_gnt;

  gnt_exp_t   g;
  rsp_exp_t   r;
  logic [1:0] ev;

  task automatic chk(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: samples just before each rising edge and pops the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      s_gnt = m_gnt;
      if (|m_gnt || (gq.size() > 0 && gq[0].cyc == cyc)) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(m_gnt), 32'd0);
        end else begin
          g = gq.pop_front();
          ev = 2'b00;
          ev[g.m] = 1'b1;
          chk("gnt_vec", 32'(m_gnt), 32'(ev));
          chk("gnt_cycle", cyc, g.cyc);
          chk("gnt_p_req", 32'(p_req), 32'd1);
          chk("gnt_p_addr", p_addr, g.addr);
          chk("gnt_p_wstrb", 32'(p_wstrb), 32'(g.wstrb));
          chk("gnt_p_wdata", p_wdata, g.wdata);
        end
      end
      if (|m_data_gnt || (rq.size() > 0 && rq[0].cyc == cyc)) begin
        if (rq.size() == 0) begin
          chk("dgnt_unexpected", 32'(m_data_gnt), 32'd0);
        end else begin
          r = rq.pop_front();
          ev = 2'b00;
          ev[r.m] = 1'b1;
          chk("dgnt_vec", 32'(m_data_gnt), 32'(ev));
          chk("dgnt_cycle", cyc, r.cyc);
          chk("err_vec", 32'(m_err), r.err ? 32'(ev) : 32'd0);
          chk("rdata_owner", m_rdata[r.m], r.rdata);
          chk("rdata_other", m_rdata[~r.m], '0);
        end
      end else if (|m_err || |m_rdata) begin
        chk("quiet_resp", 32'(m_err) | m_rdata[0] | m_rdata[1], '0);
      end
    end
  end

  task automatic push_rsp(logic m, logic [XLEN-1:0] rd, logic err);
    rsp_exp_t re;
    re.cyc   = cyc;
    re.m     = m;
    re.rdata = rd;
    re.err   = err;
    rq.push_back(re);
  endtask

  task automatic step();
    logic     idle_now;
    logic     start;
    logic     resp_now;
    gnt_exp_t ge;
    @(negedge clk);
    cyc++;
    resp_now = 1'b0;
    if (|s_gnt) chk("preq_after_gnt", 32'(p_req), 32'd0);
    idle_now = resp_last || (idle_last && req_last == 2'b00);
    start    = idle_last && (req_last != 2'b00);
    chk("preq_level", 32'(p_req), idle_last ? 32'(start) : 32'(phase == 1));
    if (start) begin
      own   = (req_last == 2'b11) ? ~last : req_last[1];
      phase = 1;
      gdly  = hold_gnt ? 1000000 : int'($urandom_range(0, 2));
    end

    for (int m = 0; m < 2; m++) begin
      if (s_gnt[m]) begin
        busy[m] = 1'b0;
        gap[m]  = $urandom_range(0, 2);
      end else if (!busy[m]) begin
        if (gap[m] > 0) begin
          gap[m]--;
        end else if (left[m] > 0) begin
          busy[m] = 1'b1;
          left[m]--;
          m_addr[m]  = $urandom;
          m_wdata[m] = $urandom;
          m_wstrb[m] = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
        end
      end
    end
    m_req = busy;

    p_gnt      = 1'b0;
    p_data_gnt = 1'b0;
    p_rdata    = $urandom;
    case (phase)
      1: begin
        if (gdly == 0) begin
          p_gnt    = 1'b1;
          ge.cyc   = cyc;
          ge.m     = own;
          ge.addr  = m_addr[own];
          ge.wdata = m_wdata[own];
          ge.wstrb = m_wstrb[own];
          gq.push_back(ge);
          if (!hold_data && $urandom_range(0, 3) == 0) begin
            p_data_gnt = 1'b1;
            push_rsp(own, p_rdata, 1'b0);
            resp_now = 1'b1;
            last     = own;
            phase    = 0;
          end else begin
            ddly  = hold_data ? 1000000 : int'($urandom_range(1, TMO + 2));
            k     = 0;
            phase = 2;
          end
        end else begin
          gdly--;
        end
      end
      2: begin
        k++;
        if (k == ddly) begin
          p_data_gnt = 1'b1;
          push_rsp(own, p_rdata, 1'b0);
          resp_now = 1'b1;
          last     = own;
          phase    = 0;
        end else if (k == TMO) begin
          push_rsp(own, '0, 1'b1);
          resp_now = 1'b1;
          last     = own;
          phase    = 3;
        end
      end
      3: begin
        // Late data grant after the watchdog fired must be ignored.
        p_data_gnt = 1'b1;
        phase      = 0;
      end
      default: ;
    endcase

    req_last  = m_req;
    idle_last = idle_now;
    resp_last = resp_now;
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    cyc++;
    arst       = 1'b1;
    m_req      = 2'b00;
    p_gnt      = 1'b0;
    p_data_gnt = 1'b0;
    p_rdata    = $urandom;
    #1;
    chk({tag, "_p_req"}, 32'(p_req), 32'd0);
    chk({tag, "_m_gnt"}, 32'(m_gnt), 32'd0);
    chk({tag, "_m_data_gnt"}, 32'(m_data_gnt), 32'd0);
    chk({tag, "_m_err"}, 32'(m_err), 32'd0);
    chk({tag, "_m_rdata0"}, m_rdata[0], '0);
    chk({tag, "_m_rdata1"}, m_rdata[1], '0);
    chk({tag, "_p_addr"}, p_addr, '0);
    chk({tag, "_p_wdata"}, p_wdata, '0);
    busy      = 2'b00;
    gap[0]    = 0;
    gap[1]    = 0;
    phase     = 0;
    last      = 1'b1;
    @(negedge clk);
    cyc++;
    arst       = 1'b0;
    p_data_gnt = 1'b1;
    p_rdata    = $urandom;
    s_gnt      = 2'b00;
    req_last   = 2'b00;
    idle_last  = 1'b1;
    resp_last  = 1'b0;
  endtask

  task automatic run_until_done(string tag, int budget);
    int n;
    n = 0;
    while (!(left[0] == 0 && left[1] == 0 && busy == 2'b00 && phase == 0 &&
             idle_last && gq.size() == 0 && rq.size() == 0)) begin
      step();
      n++;
      if (n > budget) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s_budget cyc=%0d got=%0d cycles want<=%0d", tag, cyc, n, budget);
        break;
      end
    end
  endtask

  task automatic run_until_phase(string tag, int ph, int min_k, int budget);
    int n;
    n = 0;
    while (!(phase == ph && (ph != 2 || k >= min_k))) begin
      step();
      n++;
      if (n > budget) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s_budget cyc=%0d got=%0d cycles want<=%0d", tag, cyc, n, budget);
        break;
      end
    end
  endtask

  initial begin
    arst       = 1'b1;
    m_req      = 2'b00;
    m_addr     = '0;
    m_wstrb    = '0;
    m_wdata    = '0;
    p_gnt      = 1'b0;
    p_data_gnt = 1'b0;
    p_rdata    = '0;
    busy       = 2'b00;
    left[0]    = 0;
    left[1]    = 0;
    hold_gnt   = 1'b0;
    hold_data  = 1'b0;
    s_gnt      = 2'b00;
    k          = 0;

    do_reset("reset");

    // Both requesters start together right after reset: D must win the first tie.
    left[0] = 4;
    left[1] = 4;
    run_until_done("contend", 2000);

    left[0] = 80;
    left[1] = 80;
    run_until_done("random", 20000);

    hold_gnt = 1'b1;
    left[0]  = 1;
    run_until_phase("issue_wait", 1, 0, 50);
    step();
    step();
    do_reset("rst_issue");
    hold_gnt = 1'b0;

    hold_data = 1'b1;
    left[0]   = 1;
    run_until_phase("data_wait", 2, 3, 50);
    do_reset("rst_wait");
    hold_data = 1'b0;

    left[0] = 1;
    left[1] = 1;
    run_until_done("post_reset", 2000);

    left[0] = 20;
    left[1] = 20;
    run_until_done("tail", 5000);

    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ladybird_bus_arbiter.md
# ladybird_bus_arbiter

Two-requester, one-target bus arbiter that lets the data bus and the instruction bus of the core share a single peripheral port, such as the dynamic-RAM controller. It sits between the crossbar outputs and the shared peripheral. It grants one transaction at a time, alternates priority round-robin, and holds ownership from request until data grant. A watchdog ends any transaction whose data grant never arrives, so the core cannot hang.

## Interface
Parameters:
- `XLEN`, 32, address/data width (from `ladybird_config`)
- `TIMEOUT`, 1024, max cycles from peripheral `gnt` to `data_gnt`; ≥ 2

Ports (flattened bus signals; `m` = requester index 0 = D-bus, 1 = I-bus):
- `clk` in 1: the single clock; all state changes on its rising edge
- `arst` in 1: reset, asynchronous and active-high
- `m_req[m]` in 1: request, held with addr/wstrb/wdata until `m_gnt`
- `m_addr[m]` in XLEN: address
- `m_wstrb[m]` in XLEN/8: byte write strobes, 0 = read
- `m_wdata[m]` in XLEN: write data
- `m_gnt[m]` out 1: request accepted (1-cycle pulse)
- `m_data_gnt[m]` out 1: response valid (1-cycle pulse)
- `m_rdata[m]` out XLEN: read data, valid with `m_data_gnt`
- `m_err[m]` out 1: timeout response, pulses with `m_data_gnt`
- `p_req` out 1; `p_addr` out XLEN; `p_wstrb` out XLEN/8; `p_wdata` out XLEN: to peripheral
- `p_gnt` in 1; `p_data_gnt` in 1; `p_rdata` in XLEN: from peripheral

## Operation
- FSM states: IDLE, ISSUE, WAIT_DATA. Registers: `owner` (1 b), `last` (1 b, last served), `tmo_cnt` ($clog2(TIMEOUT+1) b).
- IDLE: if any `m_req`, pick `owner`. If both requesters are active, pick `~last`; otherwise pick the single active one. Go to ISSUE. With no requests, stay in IDLE.
- ISSUE: `p_req` = 1, and `p_addr`/`p_wstrb`/`p_wdata` mux from `owner`. `m_gnt[owner]` = `p_gnt`, combinational.
  - On `p_gnt`: if `p_data_gnt` is also 1, finish (see below) and go to IDLE. Otherwise clear `tmo_cnt` and go to WAIT_DATA.
- WAIT_DATA: `p_req` = 0. `tmo_cnt` increments each cycle.
  - On `p_data_gnt`: `m_data_gnt[owner]` = 1 and `m_rdata[owner]` = `p_rdata`, combinational. `last` ← `owner`. Go to IDLE.
  - If `tmo_cnt` = TIMEOUT−1 and there is no `p_data_gnt`: `m_data_gnt[owner]` = 1, `m_err[owner]` = 1, `m_rdata` = 0. `last` ← `owner`. Go to IDLE.
- Finish = assert `m_data_gnt[owner]` and update `last`.
- The non-owner always sees `m_gnt` = 0, `m_data_gnt` = 0, `m_err` = 0 and `m_rdata` = 0.
- A `p_data_gnt` seen in IDLE (stray or late after timeout) is dropped. It is flagged only by assertion.
- Dropping `m_req` while in ISSUE is a protocol violation. Behaviour is undefined, and an assertion checks it.

## Timing
- Reset values: state = IDLE, `owner` = 0, `last` = 1 (D-bus wins the first tie), `tmo_cnt` = 0. All outputs are 0.
- Reset mid-transaction aborts to IDLE immediately (async). The peripheral is not notified, and a later `p_data_gnt` is dropped.
- Arbitration latency is one cycle: `m_req` rising at cycle N gives `p_req` = 1 at N+1.
- The gnt and data_gnt paths are combinational, with zero added latency.
- Back-to-back: the cycle after `m_data_gnt` is IDLE. The next `p_req` is at +2 cycles from the previous data grant.
- Throughput: at most one outstanding transaction.
- Fairness: under continuous contention, grants alternate D, I, D, I.
- Timeout: `m_err` fires exactly TIMEOUT cycles after the `p_gnt` cycle.

## Structure
- `ladybird_config` holds `XLEN` and a new `arb_state_t` enum (IDLE/ISSUE/WAIT_DATA) for reuse in other arbiters.
- Sub-module `ladybird_rr_pick`: a combinational 2-way round-robin chooser taking `req[1:0]` and `last`, returning `grant_idx` and `valid`. It is kept separate so it can scale to N requesters later.
- Everything else is one always_ff FSM plus output muxes.

## Test plan
- Single read: D req addr 0x2000_0010, peripheral `p_gnt` at +1 and `p_data_gnt` at +3 with 0xDEADBEEF -> `m_rdata[0]` = 0xDEADBEEF, one `m_data_gnt[0]` pulse, and I-bus outputs stay 0.
- Contention: D and I request continuously for 4 transactions after reset -> `p_addr` order D, I, D, I.
- Zero-latency peripheral: `p_gnt` and `p_data_gnt` both 1 in the ISSUE cycle -> `m_gnt` and `m_data_gnt` both pulse that cycle, and the FSM is back in IDLE next cycle.
- Timeout with TIMEOUT = 8: `p_gnt` given, `p_data_gnt` never -> `m_data_gnt` and `m_err` pulse exactly 8 cycles after `p_gnt`, with `m_rdata` = 0. A late `p_data_gnt` is then ignored.
- Write: I req with `wstrb` = 0xF and wdata 0x1234_5678 -> `p_wstrb`/`p_wdata` match during ISSUE, and `p_req` drops in the cycle after `p_gnt`.
- Reset mid-WAIT_DATA: assert `arst` for 1 cycle -> all outputs 0 at once. A new D request after release is served with D priority.
